// File: rtl/game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// game_flow_ctrl
//
// Match sequencer for the two-paddle VGA ball game. It generates the movement
// tick, gates it to the motion datapath only while the ball is in play,
// detects misses at the top and bottom edges, keeps both scores, re-serves the
// ball with a one-cycle load pulse, and runs pause and game-over.
//
// Optional feature (compile-time macro): GAME_AUTO_RESTART_EN
//   Defined   : OVER returns to IDLE by itself after OVER_TICKS ticks, clearing
//               scores and winner; start_key in OVER still re-serves.
//   Undefined : OVER is held until start_key; no OVER timeout logic exists.
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   start_key   in   one-cycle debounced start key pulse
//   pause_key   in   one-cycle debounced pause key pulse
//   ball_y      in   [9:0] ball top-left y from the motion datapath
//   ball_down   in   ball vertical direction, 1 = moving down
//   move_en     out  one-cycle motion strobe, only while in PLAY
//   ball_load   out  one-cycle pulse: reload the ball to its serve position
//   serve_down  out  serve direction used by the next ball_load
//   score1      out  [SCORE_W-1:0] bottom player score
//   score2      out  [SCORE_W-1:0] top player score
//   winner      out  [1:0] 0 = none, 1 = bottom player, 2 = top player
//   state_code  out  [2:0] IDLE=0 SERVE=1 PLAY=2 PAUSE=3 POINT=4 OVER=5
// -----------------------------------------------------------------------------
module game_flow_ctrl #(
   parameter int unsigned TICK_DIV     = 500000,
   parameter int unsigned SCORE_W      = 4,
   parameter int unsigned WIN_SCORE    = 7,
   parameter int unsigned SERVE_TICKS  = 100,
   parameter int unsigned POINT_TICKS  = 150,
   parameter int unsigned TOP_LIMIT    = 10,
   parameter int unsigned BOTTOM_LIMIT = 590
`ifdef GAME_AUTO_RESTART_EN
   ,
   parameter int unsigned OVER_TICKS   = 300
`endif
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_key,
   input  logic               pause_key,
   input  logic [9:0]         ball_y,
   input  logic               ball_down,
   output logic               move_en,
   output logic               ball_load,
   output logic               serve_down,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic [1:0]         winner,
   output logic [2:0]         state_code
);

   localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   // Phase counter only has to reach the longest timed interval minus one.
   localparam int unsigned PhaseSp = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
`ifdef GAME_AUTO_RESTART_EN
   localparam int unsigned PhaseMax = (PhaseSp > OVER_TICKS) ? PhaseSp : OVER_TICKS;
`else
   localparam int unsigned PhaseMax = PhaseSp;
`endif
   localparam int unsigned PhaseW = (PhaseMax > 1) ? $clog2(PhaseMax) : 1;

   localparam logic [TickW-1:0]   TickLast  = TickW'(TICK_DIV - 1);
   localparam logic [PhaseW-1:0]  ServeLast = PhaseW'(SERVE_TICKS - 1);
   localparam logic [PhaseW-1:0]  PointLast = PhaseW'(POINT_TICKS - 1);
`ifdef GAME_AUTO_RESTART_EN
   localparam logic [PhaseW-1:0]  OverLast  = PhaseW'(OVER_TICKS - 1);
`endif
   localparam logic [SCORE_W-1:0] WinVal    = SCORE_W'(WIN_SCORE);
   localparam logic [9:0]         TopLim    = 10'(TOP_LIMIT);
   localparam logic [9:0]         BotLim    = 10'(BOTTOM_LIMIT);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StServe = 3'd1,
      StPlay  = 3'd2,
      StPause = 3'd3,
      StPoint = 3'd4,
      StOver  = 3'd5
   } state_e;

   state_e               state_q, state_d;
   logic [TickW-1:0]     tick_cnt_q;
   logic [PhaseW-1:0]    phase_q, phase_d;
   logic                 move_en_q, move_en_d;
   logic                 ball_load_q, ball_load_d;
   logic                 serve_down_q, serve_down_d;
   logic [SCORE_W-1:0]   score1_q, score1_d;
   logic [SCORE_W-1:0]   score2_q, score2_d;
   logic [1:0]           winner_q, winner_d;

   logic tick;
   logic bottom_miss;
   logic top_miss;
   logic serve_done;
   logic point_done;
   logic score1_win;
   logic score2_win;
`ifdef GAME_AUTO_RESTART_EN
   logic over_done;
`endif

   assign tick        = (tick_cnt_q == TickLast);
   assign bottom_miss = ball_down && (ball_y >= BotLim);
   assign top_miss    = !ball_down && (ball_y <= TopLim);
   assign serve_done  = tick && (phase_q == ServeLast);
   assign point_done  = tick && (phase_q == PointLast);
   assign score1_win  = (score1_q == WinVal);
   assign score2_win  = (score2_q == WinVal);
`ifdef GAME_AUTO_RESTART_EN
   assign over_done   = tick && (phase_q == OverLast);
`endif

   // Free-running movement tick divider; runs in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt_q <= '0;
      end else if (tick) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_q + TickW'(1);
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start_key) state_d = StServe;
         end
         StServe: begin
            if (serve_done) state_d = StPlay;
         end
         StPlay: begin
            // A miss wins over a simultaneous pause request.
            if (bottom_miss || top_miss) begin
               state_d = StPoint;
            end else if (pause_key) begin
               state_d = StPause;
            end
         end
         StPause: begin
            if (pause_key) begin
               state_d = StPlay;
            end else if (start_key) begin
               state_d = StIdle;
            end
         end
         StPoint: begin
            if (point_done) begin
               state_d = (score1_win || score2_win) ? StOver : StServe;
            end
         end
         StOver: begin
            if (start_key) begin
               state_d = StServe;
`ifdef GAME_AUTO_RESTART_EN
            end else if (over_done) begin
               state_d = StIdle;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output and datapath next-state logic.
   always_comb begin
      // Phase restarts from zero on every state entry.
      if (state_d != state_q) begin
         phase_d = '0;
      end else if (tick) begin
         phase_d = phase_q + PhaseW'(1);
      end else begin
         phase_d = phase_q;
      end

      // Only ticks that fall inside PLAY reach the motion datapath.
      move_en_d    = tick && (state_q == StPlay) && (state_d == StPlay);
      ball_load_d  = (state_d == StServe) && (state_q != StServe);
      serve_down_d = serve_down_q;
      score1_d     = score1_q;
      score2_d     = score2_q;
      winner_d     = winner_q;

      unique case (state_q)
         StIdle, StOver: begin
            if (start_key) begin
               score1_d     = '0;
               score2_d     = '0;
               winner_d     = 2'd0;
               serve_down_d = 1'b1;
`ifdef GAME_AUTO_RESTART_EN
            end else if (state_d == StIdle && state_q == StOver) begin
               score1_d = '0;
               score2_d = '0;
               winner_d = 2'd0;
`endif
            end
         end
         StPlay: begin
            if (bottom_miss) begin
               if (score2_q < WinVal) score2_d = score2_q + SCORE_W'(1);
               serve_down_d = 1'b1;
            end else if (top_miss) begin
               if (score1_q < WinVal) score1_d = score1_q + SCORE_W'(1);
               serve_down_d = 1'b0;
            end
         end
         StPoint: begin
            if (point_done) begin
               if (score1_win) begin
                  winner_d = 2'd1;
               end else if (score2_win) begin
                  winner_d = 2'd2;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q      <= '0;
         move_en_q    <= 1'b0;
         ball_load_q  <= 1'b0;
         serve_down_q <= 1'b1;
         score1_q     <= '0;
         score2_q     <= '0;
         winner_q     <= 2'd0;
      end else begin
         phase_q      <= phase_d;
         move_en_q    <= move_en_d;
         ball_load_q  <= ball_load_d;
         serve_down_q <= serve_down_d;
         score1_q     <= score1_d;
         score2_q     <= score2_d;
         winner_q     <= winner_d;
      end
   end

   assign move_en    = move_en_q;
   assign ball_load  = ball_load_q;
   assign serve_down = serve_down_q;
   assign score1     = score1_q;
   assign score2     = score2_q;
   assign winner     = winner_q;
   assign state_code = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_flow_ctrl
//
// Directed match sequence plus a randomized stretch, all checked every cycle
// against a behavioural model of the match rules (mode, remaining ticks in the
// timed phases, scores). Define GAME_AUTO_RESTART_EN to also exercise the
// OVER timeout.
// -----------------------------------------------------------------------------
module tb_game_flow_ctrl;

   localparam int unsigned TickDiv     = 4;
   localparam int unsigned ScoreW      = 4;
   localparam int unsigned WinScore    = 2;
   localparam int unsigned ServeTicks  = 2;
   localparam int unsigned PointTicks  = 3;
   localparam int unsigned OverTicks   = 2;
   localparam int unsigned TopLimit    = 10;
   localparam int unsigned BottomLimit = 590;

   localparam int MIdle = 0, MServe = 1, MPlay = 2, MPause = 3, MPoint = 4, MOver = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start_key = 1'b0;
   logic              pause_key = 1'b0;
   logic [9:0]        ball_y = 10'd300;
   logic              ball_down = 1'b0;
   logic              move_en;
   logic              ball_load;
   logic              serve_down;
   logic [ScoreW-1:0] score1;
   logic [ScoreW-1:0] score2;
   logic [1:0]        winner;
   logic [2:0]        state_code;

   int checks = 0;
   int failures = 0;

   // Behavioural model state.
   int m_mode, m_cyc, m_left, m_s1, m_s2, m_win, m_sd, m_me, m_bl;

   game_flow_ctrl #(
      .TICK_DIV     (TickDiv),
      .SCORE_W      (ScoreW),
      .WIN_SCORE    (WinScore),
      .SERVE_TICKS  (ServeTicks),
      .POINT_TICKS  (PointTicks),
      .TOP_LIMIT    (TopLimit),
      .BOTTOM_LIMIT (BottomLimit)
`ifdef GAME_AUTO_RESTART_EN
      ,
      .OVER_TICKS   (OverTicks)
`endif
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_key  (start_key),
      .pause_key  (pause_key),
      .ball_y     (ball_y),
      .ball_down  (ball_down),
      .move_en    (move_en),
      .ball_load  (ball_load),
      .serve_down (serve_down),
      .score1     (score1),
      .score2     (score2),
      .winner     (winner),
      .state_code (state_code)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = MIdle;
      m_cyc  = 0;
      m_left = 0;
      m_s1   = 0;
      m_s2   = 0;
      m_win  = 0;
      m_sd   = 1;
      m_me   = 0;
      m_bl   = 0;
   endtask

   function automatic int sat_inc(input int v);
      return (v < int'(WinScore)) ? v + 1 : v;
   endfunction

   // One clock of the match rules, using the inputs present at the edge.
   task automatic model_step();
      bit tick;
      int nxt;
      tick = ((m_cyc % TickDiv) == (TickDiv - 1));
      m_cyc++;
      nxt = m_mode;
      case (m_mode)
         MIdle: begin
            if (start_key) begin
               nxt = MServe; m_s1 = 0; m_s2 = 0; m_win = 0; m_sd = 1;
            end
         end
         MServe: begin
            if (tick) begin
               m_left--;
               if (m_left == 0) nxt = MPlay;
            end
         end
         MPlay: begin
            if (ball_down && ball_y >= BottomLimit) begin
               m_s2 = sat_inc(m_s2); m_sd = 1; nxt = MPoint;
            end else if (!ball_down && ball_y <= TopLimit) begin
               m_s1 = sat_inc(m_s1); m_sd = 0; nxt = MPoint;
            end else if (pause_key) begin
               nxt = MPause;
            end
         end
         MPause: begin
            if (pause_key) nxt = MPlay;
            else if (start_key) nxt = MIdle;
         end
         MPoint: begin
            if (tick) begin
               m_left--;
               if (m_left == 0) begin
                  if (m_s1 == int'(WinScore)) begin
                     m_win = 1; nxt = MOver;
                  end else if (m_s2 == int'(WinScore)) begin
                     m_win = 2; nxt = MOver;
                  end else begin
                     nxt = MServe;
                  end
               end
            end
         end
         default: begin
            if (start_key) begin
               nxt = MServe; m_s1 = 0; m_s2 = 0; m_win = 0; m_sd = 1;
            end
`ifdef GAME_AUTO_RESTART_EN
            else if (tick) begin
               m_left--;
               if (m_left == 0) begin
                  nxt = MIdle; m_s1 = 0; m_s2 = 0; m_win = 0;
               end
            end
`endif
         end
      endcase
      m_me = (tick && m_mode == MPlay && nxt == MPlay) ? 1 : 0;
      m_bl = (nxt == MServe && m_mode != MServe) ? 1 : 0;
      if (nxt != m_mode) begin
         m_left = (nxt == MServe) ? ServeTicks :
                  (nxt == MPoint) ? PointTicks :
                  (nxt == MOver)  ? OverTicks : 0;
      end
      m_mode = nxt;
   endtask

   task automatic compare_all();
      chk("state_code", 32'(state_code), m_mode);
      chk("move_en",    32'(move_en),    m_me);
      chk("ball_load",  32'(ball_load),  m_bl);
      chk("serve_down", 32'(serve_down), m_sd);
      chk("score1",     32'(score1),     m_s1);
      chk("score2",     32'(score2),     m_s2);
      chk("winner",     32'(winner),     m_win);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic safe_ball();
      ball_y    = 10'($urandom_range(500, 100));
      ball_down = 1'($urandom_range(1, 0));
   endtask

   // Run with keys released and the ball mid-field until state_code == code.
   task automatic run_until(input int code, input int max_cyc, input string tag);
      int n;
      n = 0;
      start_key = 1'b0;
      pause_key = 1'b0;
      while (state_code !== 3'(code) && n < max_cyc) begin
         safe_ball();
         cyc();
         n++;
      end
      chk(tag, 32'(state_code), code);
   endtask

   task automatic miss(input bit bottom);
      ball_down = bottom;
      if (bottom) ball_y = 10'(BottomLimit + $urandom_range(20, 0));
      else        ball_y = 10'($urandom_range(TopLimit, 0));
      cyc();
      safe_ball();
   endtask

   task automatic pulse_start();
      start_key = 1'b1;
      cyc();
      start_key = 1'b0;
   endtask

   task automatic pulse_pause();
      pause_key = 1'b1;
      cyc();
      pause_key = 1'b0;
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      start_key = 1'b0;
      pause_key = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      compare_all();
   endtask

   initial begin
      int cnt;
      int r;

      // Power-on reset and idle; pause_key is ignored in IDLE.
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      compare_all();
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         pause_key = 1'($urandom_range(1, 0));
         safe_ball();
         cyc();
         if (move_en === 1'b1) cnt++;
      end
      pause_key = 1'b0;
      chk("idle_state", 32'(state_code), 0);
      chk("idle_move_en_count", cnt, 0);
      chk("idle_scores", 32'({score1, score2}), 0);

      // Start: SERVE next cycle with a single ball_load.
      pulse_start();
      chk("start_serve", 32'(state_code), 1);
      chk("start_ball_load", 32'(ball_load), 1);
      cyc();
      chk("ball_load_one_cycle", 32'(ball_load), 0);

      // SERVE elapses into PLAY; move_en once per TickDiv cycles.
      run_until(MPlay, 40, "serve_to_play");
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         safe_ball();
         cyc();
         if (move_en === 1'b1) cnt++;
      end
      chk("play_move_en_rate", cnt, 16 / TickDiv);

      // Bottom miss scores for the top player.
      miss(1'b1);
      chk("bottom_miss_score2", 32'(score2), 1);
      chk("bottom_miss_serve_down", 32'(serve_down), 1);
      chk("bottom_miss_point", 32'(state_code), 4);
      run_until(MServe, 40, "point_to_serve");
      chk("reserve_ball_load", 32'(ball_load), 1);

      // Two top misses: bottom player wins.
      run_until(MPlay, 40, "serve_to_play_2");
      miss(1'b0);
      chk("top_miss_score1", 32'(score1), 1);
      chk("top_miss_serve_down", 32'(serve_down), 0);
      run_until(MServe, 40, "point_to_serve_2");
      run_until(MPlay, 40, "serve_to_play_3");
      miss(1'b0);
      run_until(MOver, 40, "point_to_over");
      chk("over_winner", 32'(winner), 1);
      chk("over_score1", 32'(score1), WinScore);
      for (int i = 0; i < 5; i++) begin
         pause_key = 1'($urandom_range(1, 0));
         cyc();
      end
      pause_key = 1'b0;
      chk("over_hold_state", 32'(state_code), 5);
      chk("over_hold_score1", 32'(score1), WinScore);
      chk("over_hold_score2", 32'(score2), 1);
      pulse_start();
      chk("restart_state", 32'(state_code), 1);
      chk("restart_scores", 32'({score1, score2}), 0);
      chk("restart_winner", 32'(winner), 0);
      chk("restart_ball_load", 32'(ball_load), 1);

      // Pause holds motion, even with the ball in a miss zone.
      run_until(MPlay, 40, "serve_to_play_4");
      pulse_pause();
      chk("pause_enter", 32'(state_code), 3);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         ball_y    = 10'($urandom_range(1023, 0));
         ball_down = 1'($urandom_range(1, 0));
         cyc();
         if (move_en === 1'b1) cnt++;
      end
      chk("pause_move_en_count", cnt, 0);
      chk("pause_no_score", 32'({score1, score2}), 0);
      safe_ball();
      pulse_pause();
      chk("pause_resume", 32'(state_code), 2);

      // Miss beats a simultaneous pause.
      pause_key = 1'b1;
      miss(1'b1);
      pause_key = 1'b0;
      chk("miss_vs_pause_state", 32'(state_code), 4);
      chk("miss_vs_pause_score2", 32'(score2), 1);

      // Asynchronous reset in the middle of SERVE.
      run_until(MServe, 40, "point_to_serve_3");
      cyc();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_state", 32'(state_code), 0);
      chk("rst_move_en", 32'(move_en), 0);
      chk("rst_ball_load", 32'(ball_load), 0);
      chk("rst_serve_down", 32'(serve_down), 1);
      chk("rst_scores", 32'({score1, score2}), 0);
      chk("rst_winner", 32'(winner), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (ball_load === 1'b1) cnt++;
      end
      chk("rst_no_ball_load", cnt, 0);

      // PAUSE + start_key returns to IDLE with scores held.
      pulse_start();
      run_until(MPlay, 40, "serve_to_play_5");
      miss(1'b1);
      run_until(MPlay, 60, "point_to_play");
      pulse_pause();
      pulse_start();
      chk("pause_to_idle", 32'(state_code), 0);
      chk("pause_to_idle_score2", 32'(score2), 1);

      // Randomized stretch against the model.
      for (int i = 0; i < 1500; i++) begin
         start_key = ($urandom_range(19, 0) == 0);
         pause_key = ($urandom_range(14, 0) == 0);
         ball_down = 1'($urandom_range(1, 0));
         r = int'($urandom_range(3, 0));
         if (r == 0)      ball_y = 10'($urandom_range(15, 0));
         else if (r == 1) ball_y = 10'($urandom_range(600, 580));
         else             ball_y = 10'($urandom_range(500, 100));
         cyc();
      end
      start_key = 1'b0;
      pause_key = 1'b0;

`ifdef GAME_AUTO_RESTART_EN
      // OVER times out to IDLE and clears the match.
      do_reset();
      pulse_start();
      run_until(MPlay, 40, "ar_serve_to_play");
      miss(1'b1);
      run_until(MPlay, 60, "ar_point_to_play");
      miss(1'b1);
      run_until(MOver, 40, "ar_point_to_over");
      chk("ar_over_winner", 32'(winner), 2);
      run_until(MIdle, 4 * TickDiv * OverTicks, "ar_over_to_idle");
      chk("ar_scores_cleared", 32'({score1, score2}), 0);
      chk("ar_winner_cleared", 32'(winner), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Match sequencer for the two-paddle VGA ball game.
- Owns the 10 ms movement tick and gates it to the ball/paddle motion datapath (move_en); only PLAY advances the ball.
- Detects misses at the top and bottom edges, keeps both scores, and re-serves the ball through a one-cycle load pulse.
- Runs pause and game-over; the renderer consumes state_code, scores and winner.

Parameters:
- TICK_DIV, 500000: clk cycles per movement tick (10 ms at 50 MHz).
- SCORE_W, 4: score counter width.
- WIN_SCORE, 7: points needed to win; must be below 2^SCORE_W.
- SERVE_TICKS, 100: ticks spent in SERVE before PLAY.
- POINT_TICKS, 150: ticks spent in POINT after a miss.
- OVER_TICKS, 300: ticks in OVER before auto-restart (optional feature only).
- TOP_LIMIT, 10: ball_y at or below this while moving up is a top miss.
- BOTTOM_LIMIT, 590: ball_y at or above this while moving down is a bottom miss.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_key  in  1  one-cycle debounced key pulse.
- pause_key  in  1  one-cycle debounced key pulse.
- ball_y  in  10  ball top-left y from the motion datapath.
- ball_down  in  1  ball vertical direction: 1 = moving down.
- move_en  out  1  one-cycle motion strobe; asserted only in PLAY.
- ball_load  out  1  one-cycle pulse: datapath reloads the ball to its serve position.
- serve_down  out  1  serve direction for the next ball_load.
- score1  out  SCORE_W  bottom player score.
- score2  out  SCORE_W  top player score.
- winner  out  2  0 = none, 1 = bottom player, 2 = top player.
- state_code  out  3  IDLE=0, SERVE=1, PLAY=2, PAUSE=3, POINT=4, OVER=5.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: state IDLE, tick counter 0, phase counter 0, move_en 0, ball_load 0, serve_down 1, score1 0, score2 0, winner 0.
- Tick generator:
  - Free-running counter 0..TICK_DIV-1; tick is high on the cycle it equals TICK_DIV-1.
  - It runs in every state.
- move_en = tick AND state==PLAY. It is registered and high exactly one cycle.
- Phase counter: cleared on every state entry; increments on tick.
- IDLE:
  - start_key -> SERVE; clear scores and winner; serve_down=1; pulse ball_load the next cycle.
  - pause_key is ignored.
- SERVE: when phase counter reaches SERVE_TICKS-1 and tick -> PLAY.
- PLAY:
  - Bottom miss (ball_down=1 and ball_y>=BOTTOM_LIMIT): score2+1, serve_down=1, -> POINT.
  - Top miss (ball_down=0 and ball_y<=TOP_LIMIT): score1+1, serve_down=0, -> POINT.
  - The score updates on the same edge as the state change; at most one miss per PLAY entry.
  - pause_key -> PAUSE. A miss on the same cycle has priority over pause_key.
- PAUSE:
  - pause_key -> PLAY.
  - start_key -> IDLE; scores are held.
  - move_en stays 0.
- POINT: when phase counter reaches POINT_TICKS-1 and tick:
  - If a score equals WIN_SCORE: set winner -> OVER.
  - Else -> SERVE with a ball_load pulse.
- OVER:
  - Scores and winner are held.
  - start_key -> SERVE exactly as from IDLE.
- start_key and pause_key are ignored in SERVE and POINT.
- ball_load fires on every SERVE entry, one cycle after the transition edge, and lasts one cycle.
- Scores never exceed WIN_SCORE; no wrap-around.
- Reset mid-operation: all outputs return to reset values immediately; no ball_load is issued.

Optional Feature:
- Macro: GAME_AUTO_RESTART_EN.
- Defined: in OVER, when phase counter reaches OVER_TICKS-1 and tick -> IDLE; scores and winner are cleared on entry to IDLE. start_key in OVER still works.
- Undefined: OVER is held until start_key; no OVER_TICKS logic is synthesized.

Test Plan:
(Bench parameters: TICK_DIV=4, SERVE_TICKS=2, POINT_TICKS=3, WIN_SCORE=2.)
- Reset, then idle 20 cycles -> state_code=0, move_en never 1, scores 0; start_key -> state_code=1 next cycle, ball_load high for exactly 1 cycle.
- After SERVE elapses -> state_code=2; move_en pulses once every 4 cycles.
- In PLAY drive ball_down=1, ball_y=590 -> score2=1, serve_down=1, state_code=4; after 3 ticks -> SERVE with ball_load.
- ball_down=0, ball_y=10 twice across points -> score1=2, winner=1, state_code=5; scores hold; start_key -> scores 0, SERVE.
- In PLAY, pause_key -> state_code=3, no move_en for 40 cycles; pause_key -> PLAY. In PLAY, miss and pause_key on the same cycle -> POINT.
- Assert rst_n=0 mid-SERVE -> all outputs at reset values asynchronously. With GAME_AUTO_RESTART_EN and OVER_TICKS=2, OVER -> IDLE after 2 ticks with scores cleared.
